// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the pipelined CPU memory path.
package rv32i_types;
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes data and fetch requests onto one memory port and returns both responses together.
module mem_port_arbiter
  import rv32i_types::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_read,
  input  logic [WIDTH-1:0] imem_address,
  output logic             imem_resp,
  output logic [WIDTH-1:0] imem_rdata,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic [WIDTH-1:0] dmem_address,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic [3:0]       dmem_byte_enable,
  output logic             dmem_resp,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_byte_enable,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata
);
  arb_state_t state, next_state;
  logic i_pend, d_pend, d_wr;
  logic [WIDTH-1:0] i_addr, d_addr, d_wdata;
  logic [3:0] d_be;
  // The bundle is only loaded in IDLE, so requester changes mid-access are invisible downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i_pend     <= 1'b0;
      d_pend     <= 1'b0;
      d_wr       <= 1'b0;
      i_addr     <= '0;
      d_addr     <= '0;
      d_wdata    <= '0;
      d_be       <= '0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        i_pend  <= imem_read;
        d_pend  <= dmem_read | dmem_write;
        d_wr    <= dmem_write;
        i_addr  <= imem_address;
        d_addr  <= dmem_address;
        d_wdata <= dmem_wdata;
        d_be    <= dmem_byte_enable;
      end
      if (state == I_ACC && mem_resp) imem_rdata <= mem_rdata;
      if (state == D_ACC && mem_resp && !d_wr) dmem_rdata <= mem_rdata;
    end
  end
  always_comb begin
    next_state      = state;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = 4'h0;
    imem_resp       = 1'b0;
    dmem_resp       = 1'b0;
    case (state)
      IDLE: next_state = (dmem_read | dmem_write) ? D_ACC : imem_read ? I_ACC : IDLE;
      D_ACC: begin
        mem_read        = !d_wr;
        mem_write       = d_wr;
        mem_address     = d_addr;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_wr ? d_be : 4'hF;
        if (mem_resp) next_state = i_pend ? I_ACC : DONE;
      end
      I_ACC: begin
        mem_read        = 1'b1;
        mem_address     = i_addr;
        mem_byte_enable = 4'hF;
        if (mem_resp) next_state = DONE;
      end
      DONE: begin
        imem_resp  = i_pend;
        dmem_resp  = d_pend;
        next_state = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector bench for the shared memory port arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic imem_read = 1'b0, dmem_read = 1'b0, dmem_write = 1'b0, mem_resp = 1'b0;
  logic [31:0] imem_address = '0, dmem_address = '0, dmem_wdata = '0, mem_rdata = '0;
  logic [3:0] dmem_byte_enable = '0;
  logic imem_resp, dmem_resp, mem_read, mem_write;
  logic [31:0] imem_rdata, dmem_rdata, mem_address, mem_wdata;
  logic [3:0] mem_byte_enable;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic ird, drd, dwr;
    logic [31:0] iaddr, daddr, wdata;
    logic [3:0] be;
    int waits;
    logic [31:0] i_ret, d_ret, exp_i, exp_d;
  } vec_t;
  vec_t vecs[7];

  mem_port_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imem_read = v.ird;
    dmem_read = v.drd;
    dmem_write = v.dwr;
    imem_address = v.iaddr;
    dmem_address = v.daddr;
    dmem_wdata = v.wdata;
    dmem_byte_enable = v.be;
  endtask

  task automatic clear_req();
    imem_read = 1'b0;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
  endtask

  // Starts at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run(input vec_t v, input vec_t nx, input bit has_nx);
    bit dop = v.drd | v.dwr;
    drive(v);
    @(negedge clk);
    clear_req();
    imem_address = v.iaddr + 32'd4;
    dmem_address = ~v.daddr;
    dmem_wdata = ~v.wdata;
    dmem_byte_enable = ~v.be;
    if (dop)
      for (int w = 0; w <= v.waits; w++) begin
        chk("d_read", {31'd0, mem_read}, {31'd0, !v.dwr});
        chk("d_write", {31'd0, mem_write}, {31'd0, v.dwr});
        chk("d_addr", mem_address, v.daddr);
        chk("d_be", {28'd0, mem_byte_enable}, {28'd0, v.dwr ? v.be : 4'hF});
        if (v.dwr) chk("d_wdata", mem_wdata, v.wdata);
        chk("d_no_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
        mem_resp = (w == v.waits);
        mem_rdata = v.d_ret;
        @(negedge clk);
      end
    if (v.ird)
      for (int w = 0; w <= v.waits; w++) begin
        chk("i_cmd", {30'd0, mem_read, mem_write}, 32'd2);
        chk("i_addr", mem_address, v.iaddr);
        chk("i_be", {28'd0, mem_byte_enable}, 32'hF);
        chk("i_no_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
        mem_resp = (w == v.waits);
        mem_rdata = v.i_ret;
        @(negedge clk);
      end
    chk("done_imem_resp", {31'd0, imem_resp}, {31'd0, v.ird});
    chk("done_dmem_resp", {31'd0, dmem_resp}, {31'd0, dop});
    chk("done_imem_rdata", imem_rdata, v.exp_i);
    chk("done_dmem_rdata", dmem_rdata, v.exp_d);
    chk("done_cmd", {30'd0, mem_read, mem_write}, 32'd0);
    mem_resp = 1'b0;
    if (has_nx) drive(nx);
    @(negedge clk);
    chk("idle_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    chk("idle_cmd", {30'd0, mem_read, mem_write}, 32'd0);
    chk("idle_imem_rdata", imem_rdata, v.exp_i);
    chk("idle_dmem_rdata", dmem_rdata, v.exp_d);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 4'h0, 0, 32'h00000013, 32'h0, 32'h00000013, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h64, 32'h100, 32'h0, 4'h0, 0, 32'h00A00093, 32'hDEADBEEF, 32'h00A00093, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h68, 32'h103, 32'h11000000, 4'h8, 2, 32'h12345678, 32'hBAD0BAD0, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 4'h0, 1, 32'h0, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h204, 32'h0000ABCD, 4'h3, 0, 32'h0, 32'h55555555, 32'h12345678, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h6C, 32'h0, 32'h0, 4'h0, 3, 32'h00000073, 32'h0, 32'h00000073, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 4'h0, 0, 32'h00100073, 32'h0, 32'h00100073, 32'h0};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_be", {28'd0, mem_byte_enable}, 32'd0);
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run(vecs[i], (i < 5) ? vecs[i+1] : vecs[i], i < 5);
    // A stray completion while idle must be ignored.
    mem_resp = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("spur_cmd", {30'd0, mem_read, mem_write}, 32'd0);
      chk("spur_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
      chk("spur_imem_rdata", imem_rdata, 32'h00000073);
      chk("spur_dmem_rdata", dmem_rdata, 32'hCAFEF00D);
    end
    mem_resp = 1'b0;
    // Reset in the middle of a data read abandons it.
    imem_read = 1'b1;
    imem_address = 32'h70;
    dmem_read = 1'b1;
    dmem_address = 32'h300;
    @(negedge clk);
    chk("pre_rst_read", {31'd0, mem_read}, 32'd1);
    chk("pre_rst_addr", mem_address, 32'h300);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_read", {31'd0, mem_read}, 32'd0);
    chk("mid_rst_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd", {30'd0, mem_read, mem_write}, 32'd0);
    chk("post_rst_resp", {30'd0, imem_resp, dmem_resp}, 32'd0);
    chk("post_rst_imem_rdata", imem_rdata, 32'd0);
    chk("post_rst_dmem_rdata", dmem_rdata, 32'd0);
    run(vecs[6], vecs[6], 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
